// File: rtl/irq_encoder8_pkg.sv
// Shared types, width constants and the lowest-index priority function for
// the eight-line interrupt encoder.
package irq_encoder8_pkg;

    localparam int unsigned IRQ_N = 8;
    localparam int unsigned IRQ_W = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StServ = 2'd2
    } irq_state_e;

    // Returns {valid, num}; index 0 wins, so scan downwards and let lower
    // indices overwrite.
    function automatic logic [IRQ_W:0] prio_enc8(input logic [0:IRQ_N-1] sel);
        logic [IRQ_W:0] res;
        res = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (sel[i]) begin
                res = {1'b1, IRQ_W'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_encoder8_prio_enc8.sv
// Combinational lowest-index priority encoder with valid flag; the counterpart
// of the system's 3-to-8 decoders.
module prio_enc8
    import irq_encoder8_pkg::*;
(
    input  logic [0:IRQ_N-1] sel_i,
    output logic             valid_o,
    output logic [0:IRQ_W-1] num_o
);

    always_comb begin
        {valid_o, num_o} = irq_encoder8_pkg::prio_enc8(sel_i);
    end

endmodule

// File: rtl/irq_encoder8.sv
// Interrupt encoder: latches requests, masks, picks the lowest-index channel
// and presents it over an irq/ack handshake, tracking it until eoi.
module irq_encoder8
    import irq_encoder8_pkg::*;
#(
    parameter bit               AUTO_EOI  = 1'b0,
    parameter logic [0:IRQ_N-1] PEND_INIT = 8'h00
) (
    input  logic             clk_sys,
    input  logic             _rst,
    input  logic [0:IRQ_N-1] req,
    input  logic [0:IRQ_N-1] mask,
    input  logic [0:IRQ_N-1] clr,
    input  logic             ack,
    input  logic             eoi,
    output logic             irq,
    output logic [0:IRQ_W-1] num,
    output logic [0:IRQ_N-1] pend,
    output logic             busy
);

    irq_state_e       state_q, state_d;
    logic [0:IRQ_N-1] pend_q, pend_d;
    logic             irq_q, irq_d;
    logic [0:IRQ_W-1] num_q, num_d;
    logic             busy_q, busy_d;

    logic [0:IRQ_N-1] sel;
    logic [0:IRQ_N-1] ackclr;
    logic             ack_hit;
    logic             win_valid;
    logic [0:IRQ_W-1] win_num;

    assign sel = pend_q & mask;

    prio_enc8 u_prio_enc8 (
        .sel_i   (sel),
        .valid_o (win_valid),
        .num_o   (win_num)
    );

    always_comb begin
        ack_hit = (state_q == StReq) && ack;
        ackclr  = '0;
        if (ack_hit) begin
            ackclr[num_q] = 1'b1;
        end
        // A request in the same cycle always wins over any clear.
        pend_d  = (pend_q & ~clr & ~ackclr) | req;

        state_d = state_q;
        irq_d   = irq_q;
        num_d   = num_q;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    num_d   = win_num;
                    irq_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ack_hit) begin
                    irq_d = 1'b0;
                    if (AUTO_EOI) begin
                        state_d = StIdle;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = StServ;
                    end
                end else if (!pend_d[num_q] || !mask[num_q]) begin
                    // Request vanished before the CPU took it; num is kept.
                    irq_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            StServ: begin
                if (eoi) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                irq_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge _rst) begin
        if (!_rst) begin
            state_q <= StIdle;
            pend_q  <= PEND_INIT;
            irq_q   <= 1'b0;
            num_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            num_q   <= num_d;
            busy_q  <= busy_d;
        end
    end

    assign irq  = irq_q;
    assign num  = num_q;
    assign pend = pend_q;
    assign busy = busy_q;

endmodule

// File: doc/irq_encoder8.md
Name: irq_encoder8

Overview:
- Inverse of the system's 3-to-8 line decoders: encodes eight interrupt request lines into a registered 3-bit channel number.
- Latches and holds requests, applies a mask, and selects by fixed priority.
- Presents one interrupt at a time to the CPU control logic over an irq/ack handshake.
- Tracks the in-service interrupt until end-of-interrupt (eoi).
- Sits between the peripheral/channel interrupt sources and the CPU interrupt-accept sequencer.

Parameters:
- AUTO_EOI, 0: when 1, the in-service phase is skipped and ack returns directly to IDLE.
- PEND_INIT, 8'h00: reset value of the pending register.

Ports:
- clk_sys  in  1  system clock; all state changes on its rising edge.
- _rst  in  1  asynchronous, active-low reset.
- req  in  [0:7]  request lines, sampled every cycle; 1 sets the matching pending bit; bit 0 is highest priority.
- mask  in  [0:7]  1 = channel enabled for selection; pending bits are still latched while masked.
- clr  in  [0:7]  per-channel clear of pending, synchronous.
- ack  in  1  CPU accepts the presented interrupt; meaningful only while irq=1.
- eoi  in  1  end of interrupt; meaningful only in SERV.
- irq  out  1  interrupt presented, registered.
- num  out  [0:2]  number of the presented/in-service channel; num[0] is the MSB.
- pend  out  [0:7]  current pending register, for status readout.
- busy  out  1  1 while in SERV.

Behaviour:
- Reset (_rst=0, asynchronous):
  - pend=PEND_INIT, irq=0, num=0, busy=0, state=IDLE.
  - Reset mid-handshake drops everything immediately. No irq in the first cycle after release.
- Pending update each clock: pend_next = (pend & ~clr & ~ackclr) | req.
  - ackclr is the one-hot of num, applied only in the ack cycle.
  - Set beats clear: a req on a channel cleared in the same cycle leaves the bit set.
- Selection: sel = pend & mask. The winner is the lowest index with sel=1.
- States:
  - IDLE:
    - If sel≠0: num<=winner, irq<=1, go to REQ. irq rises 1 cycle after pend&mask first becomes nonzero; with pend previously clear, req asserted in cycle t gives irq=1 at t+2.
    - Otherwise stay.
  - REQ:
    - irq=1 and num is frozen. A newly arriving higher-priority request does not preempt.
    - On ack: pend[num] cleared, irq<=0. If AUTO_EOI=0, busy<=1 and go to SERV; if AUTO_EOI=1, go to IDLE.
    - If pend[num] is cleared by clr or mask[num] drops before ack: irq<=0, go to IDLE (withdraw), num retained. ack has priority over withdraw in the same cycle.
  - SERV:
    - busy=1, irq=0, num holds the in-service channel. Pending bits continue to latch; no new irq is presented.
    - On eoi: busy<=0, go to IDLE. Re-arbitration happens in IDLE on the next cycle, so the next irq rises 2 cycles after eoi.
- Ignored inputs: ack outside REQ; eoi outside SERV.
- Wrap/boundary cases:
  - All 8 pending: served in order 0..7.
  - mask=0: no irq, pend still accumulates.
  - Channel 7 alone: num=3'b111.

Decomposition:
- Shared package:
  - state enum {IDLE, REQ, SERV}.
  - Width constants IRQ_N=8 and IRQ_W=3.
  - A function prio_enc8(sel) -> {valid, num}.
- Optional sub-module: prio_enc8, combinational lowest-index priority encoder with valid. It is the natural counterpart to decoder8 and reusable elsewhere; the remainder stays in irq_encoder8.

Test Plan:
- Reset value: reset with PEND_INIT=8'h00, release, then req=8'b0010_0000 for 1 cycle, mask=8'hFF -> pend=8'b0010_0000 next cycle; irq=1 and num=3'd2 one cycle later.
- Priority and serialisation: req=8'b0100_0001 (channels 1,7) simultaneously -> num=1 first; ack -> busy=1, pend=8'b0000_0001; eoi -> irq again with num=7 two cycles later.
- Masking: mask=8'b0111_1111 with req on channel 0 -> no irq, pend[0]=1. Set mask=8'hFF -> irq with num=0 next cycle.
- Withdraw and no preempt:
  - Channel 4 presented; clr=8'b0000_1000 before ack -> irq drops, state IDLE.
  - Separately, req ch0 during REQ for ch4 -> num stays 4 until ack.
- Set-beats-clear and AUTO_EOI:
  - ack of ch3 with req[3]=1 in the same cycle -> pend[3] remains 1.
  - With AUTO_EOI=1, busy stays 0 and ch3 is re-presented 1 cycle after returning to IDLE.
- Async reset mid-SERV: assert _rst=0 between clock edges -> irq, busy, pend, num cleared immediately without a clock edge.
